// File: rtl/sd_dat_reader.sv
// SD-card DAT-line receiver for single- and multi-block reads.
// Samples the card clock level from sdcmd_ctrl as a data strobe. Each received
// byte is streamed out with its address. The per-line CRC16 and the end bit
// are checked for every block.
// Handshake: start/stop are single-cycle requests. start is honoured only when
// the block is idle. stop wins over start. outen qualifies outbyte/outaddr/outblk
// for one cycle, and there is no back-pressure.
module sd_dat_reader #(
    parameter int          DAT_WIDTH = 1,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 sdclk,
    input  logic [DAT_WIDTH-1:0] sddat,
    input  logic                 start,
    input  logic [15:0]          nblocks,
    input  logic                 stop,
    output logic                 busy,
    output logic                 outen,
    output logic [7:0]           outbyte,
    output logic [8:0]           outaddr,
    output logic [15:0]          outblk,
    output logic                 blk_done,
    output logic                 blk_crc_ok,
    output logic                 crc_err,
    output logic                 done,
    output logic                 timeout
);

    if (!(DAT_WIDTH == 1 || DAT_WIDTH == 4)) begin : g_bad_width
        $error("sd_dat_reader: DAT_WIDTH must be 1 or 4");
    end

    // Number of DAT samples in one 512-byte payload, and how bytes map onto them
    localparam logic [11:0] DATA_LAST  = 12'(4096 / DAT_WIDTH - 1);
    localparam logic [11:0] BYTE_MASK  = (DAT_WIDTH == 4) ? 12'd1 : 12'd7;
    localparam int          ADDR_SHIFT = (DAT_WIDTH == 4) ? 1 : 3;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_CRC, S_ENDB} state_t;

    state_t      state;
    logic        sdclk_l;
    logic [15:0] nblk_q;
    logic [31:0] ecnt;
    logic [11:0] bcnt;
    logic [7:0]  shreg;
    logic [15:0] crc_calc [DAT_WIDTH];
    logic [15:0] crc_rx   [DAT_WIDTH];

    logic        sample;
    logic        start_bit;
    logic        byte_done;
    logic        last_blk;
    logic        end_ok;
    logic        crc_match;
    logic [7:0]  byte_next;
    logic [31:0] ecnt_next;

    // Serial CRC16-CCITT step (x^16 + x^12 + x^5 + 1) for one data bit
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign sample    = sdclk & ~sdclk_l;
    assign start_bit = (sddat == '0);
    assign byte_done = ((bcnt & BYTE_MASK) == BYTE_MASK);
    assign last_blk  = (outblk == nblk_q - 16'd1);
    assign end_ok    = &sddat;
    assign byte_next = 8'({shreg, sddat});
    assign ecnt_next = ecnt + 32'd1;

    // All lines must agree between the locally computed and the received CRC
    always_comb begin
        crc_match = 1'b1;
        for (int i = 0; i < DAT_WIDTH; i++) begin
            if (crc_calc[i] != crc_rx[i]) crc_match = 1'b0;
        end
    end

    // Previous card-clock level for rising-edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sdclk_l <= 1'b0;
        else       sdclk_l <= sdclk;
    end

    // Receive FSM: start-bit hunt, payload, CRC, end bit, repeated per block
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            nblk_q     <= '0;
            ecnt       <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            busy       <= 1'b0;
            outen      <= 1'b0;
            outbyte    <= '0;
            outaddr    <= '0;
            outblk     <= '0;
            blk_done   <= 1'b0;
            blk_crc_ok <= 1'b0;
            crc_err    <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            for (int i = 0; i < DAT_WIDTH; i++) begin
                crc_calc[i] <= '0;
                crc_rx[i]   <= '0;
            end
        end else begin
            outen    <= 1'b0;
            blk_done <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            if (stop) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            nblk_q  <= (nblocks == 16'd0) ? 16'd1 : nblocks;
                            outblk  <= '0;
                            crc_err <= 1'b0;
                            ecnt    <= '0;
                            busy    <= 1'b1;
                            state   <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (sample) begin
                            if (start_bit) begin
                                bcnt  <= '0;
                                state <= S_DATA;
                                for (int i = 0; i < DAT_WIDTH; i++) begin
                                    crc_calc[i] <= '0;
                                    crc_rx[i]   <= '0;
                                end
                            end else begin
                                ecnt <= ecnt_next;
                                if (ecnt_next >= TIMEOUT) begin
                                    timeout <= 1'b1;
                                    busy    <= 1'b0;
                                    state   <= S_IDLE;
                                end
                            end
                        end
                    end
                    S_DATA: begin
                        if (sample) begin
                            for (int i = 0; i < DAT_WIDTH; i++) begin
                                crc_calc[i] <= crc16_step(crc_calc[i], sddat[i]);
                            end
                            shreg <= byte_next;
                            if (byte_done) begin
                                outen   <= 1'b1;
                                outbyte <= byte_next;
                                outaddr <= 9'(bcnt >> ADDR_SHIFT);
                            end
                            if (bcnt == DATA_LAST) begin
                                bcnt  <= '0;
                                state <= S_CRC;
                            end else begin
                                bcnt <= bcnt + 12'd1;
                            end
                        end
                    end
                    S_CRC: begin
                        if (sample) begin
                            for (int i = 0; i < DAT_WIDTH; i++) begin
                                crc_rx[i] <= {crc_rx[i][14:0], sddat[i]};
                            end
                            if (bcnt == 12'd15) begin
                                bcnt  <= '0;
                                state <= S_ENDB;
                            end else begin
                                bcnt <= bcnt + 12'd1;
                            end
                        end
                    end
                    S_ENDB: begin
                        if (sample) begin
                            blk_done   <= 1'b1;
                            blk_crc_ok <= crc_match & end_ok;
                            if (!(crc_match && end_ok)) crc_err <= 1'b1;
                            if (last_blk) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end else begin
                                outblk <= outblk + 16'd1;
                                ecnt   <= '0;
                                state  <= S_WAIT;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_dat_reader.sv
// Directed bench for sd_dat_reader: a 1-bit and a 4-bit instance share clock,
// reset and card clock; each is driven only while the other sits idle.
module tb_sd_dat_reader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sdclk;

    logic [0:0]  sddat1;
    logic        start1, stop1;
    logic [15:0] nblocks1;
    logic        busy1, outen1, blk_done1, blk_crc_ok1, crc_err1, done1, timeout1;
    logic [7:0]  outbyte1;
    logic [8:0]  outaddr1;
    logic [15:0] outblk1;

    logic [3:0]  sddat4;
    logic        start4, stop4;
    logic [15:0] nblocks4;
    logic        busy4, outen4, blk_done4, blk_crc_ok4, crc_err4, done4, timeout4;
    logic [7:0]  outbyte4;
    logic [8:0]  outaddr4;
    logic [15:0] outblk4;

    int errors = 0;
    int checks = 0;

    // Scoreboard: expected {blk, addr, byte} per DUT, and what the monitor saw
    logic [32:0] exp_q1[$];
    logic [32:0] exp_q4[$];
    logic [32:0] got_q1[$];
    logic [32:0] got_q4[$];

    int n_blk1 = 0, n_ok1 = 0, n_done1 = 0, n_to1 = 0;
    int n_blk4 = 0, n_ok4 = 0, n_done4 = 0, n_to4 = 0;
    int done_blk4 = -1;
    logic [7:0] ok_hist4 = '0;

    int b_blk, b_ok, b_done, b_to;

    sd_dat_reader #(.DAT_WIDTH(1), .TIMEOUT(100)) u1 (
        .clk(clk), .rstn(rstn), .sdclk(sdclk), .sddat(sddat1),
        .start(start1), .nblocks(nblocks1), .stop(stop1),
        .busy(busy1), .outen(outen1), .outbyte(outbyte1), .outaddr(outaddr1),
        .outblk(outblk1), .blk_done(blk_done1), .blk_crc_ok(blk_crc_ok1),
        .crc_err(crc_err1), .done(done1), .timeout(timeout1)
    );

    sd_dat_reader #(.DAT_WIDTH(4), .TIMEOUT(100)) u4 (
        .clk(clk), .rstn(rstn), .sdclk(sdclk), .sddat(sddat4),
        .start(start4), .nblocks(nblocks4), .stop(stop4),
        .busy(busy4), .outen(outen4), .outbyte(outbyte4), .outaddr(outaddr4),
        .outblk(outblk4), .blk_done(blk_done4), .blk_crc_ok(blk_crc_ok4),
        .crc_err(crc_err4), .done(done4), .timeout(timeout4)
    );

    // Clock
    always #5 clk = ~clk;

    // Monitor: record strobes and pulses away from the active edge
    always @(negedge clk) begin
        if (outen1) got_q1.push_back({outblk1, outaddr1, outbyte1});
        if (outen4) got_q4.push_back({outblk4, outaddr4, outbyte4});
        if (blk_done1) begin
            n_blk1++;
            if (blk_crc_ok1) n_ok1++;
        end
        if (blk_done4) begin
            n_blk4++;
            if (blk_crc_ok4) n_ok4++;
            ok_hist4 = {ok_hist4[6:0], blk_crc_ok4};
        end
        if (done1) n_done1++;
        if (done4) begin
            n_done4++;
            done_blk4 = blk_done4 ? n_blk4 : -1;
        end
        if (timeout1) n_to1++;
        if (timeout4) n_to4++;
    end

    // Watchdog so the run always ends
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
        logic        fb;
        logic [15:0] n;
        fb    = c[15] ^ b;
        n     = c << 1;
        n[0]  = fb;
        n[5]  = c[4] ^ fb;
        n[12] = c[11] ^ fb;
        return n;
    endfunction

    // One card-clock period: low for a cycle, then high; DUT samples d on the rise
    task automatic sd_edge(input logic d1, input logic [3:0] d4);
        sdclk  = 1'b0;
        sddat1 = d1;
        sddat4 = d4;
        @(posedge clk); #1;
        sdclk = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle_edges(input int n);
        for (int i = 0; i < n; i++) sd_edge(1'b1, 4'hF);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int dut, input bit is_stop);
        if (dut == 1) begin
            if (is_stop) stop1 = 1'b1; else start1 = 1'b1;
        end else begin
            if (is_stop) stop4 = 1'b1; else start4 = 1'b1;
        end
        @(posedge clk); #1;
        start1 = 1'b0; stop1 = 1'b0; start4 = 1'b0; stop4 = 1'b0;
    endtask

    // 1-bit block 0: payload i & 0xFF; full blocks get CRC and end bit
    task automatic send_block1(input int nbytes);
        logic [15:0] crc;
        logic [7:0]  v;
        crc = '0;
        sd_edge(1'b0, 4'hF);
        for (int i = 0; i < nbytes; i++) begin
            v = 8'(i & 255);
            exp_q1.push_back({16'd0, 9'(i), v});
            for (int k = 7; k >= 0; k--) begin
                crc = crc_upd(crc, v[k]);
                sd_edge(v[k], 4'hF);
            end
        end
        if (nbytes == 512) begin
            for (int k = 15; k >= 0; k--) sd_edge(crc[k], 4'hF);
            sd_edge(1'b1, 4'hF);
        end
    endtask

    // 4-bit block b: payload (i+b) & 0xFF; optional flip of CRC bit 5 on DAT2
    task automatic send_block4(input int b, input int nbytes, input bit flip);
        logic [15:0] crc [4];
        logic [7:0]  v;
        logic [3:0]  nib;
        for (int j = 0; j < 4; j++) crc[j] = '0;
        sd_edge(1'b1, 4'h0);
        for (int i = 0; i < nbytes; i++) begin
            v = 8'((i + b) & 255);
            exp_q4.push_back({16'(b), 9'(i), v});
            nib = v[7:4];
            for (int j = 0; j < 4; j++) crc[j] = crc_upd(crc[j], nib[j]);
            sd_edge(1'b1, nib);
            nib = v[3:0];
            for (int j = 0; j < 4; j++) crc[j] = crc_upd(crc[j], nib[j]);
            sd_edge(1'b1, nib);
        end
        if (nbytes == 512) begin
            for (int k = 0; k < 16; k++) begin
                for (int j = 0; j < 4; j++) nib[j] = crc[j][15-k];
                if (flip && k == 10) nib[2] = ~nib[2];
                sd_edge(1'b1, nib);
            end
            sd_edge(1'b1, 4'hF);
        end
    endtask

    // Compare observed bytes against the expected queue, then empty both
    task automatic drain(input int dut, input string tag);
        int n;
        if (dut == 1) begin
            chk({tag, "_count"}, 64'(got_q1.size()), 64'(exp_q1.size()));
            n = (got_q1.size() < exp_q1.size()) ? got_q1.size() : exp_q1.size();
            for (int i = 0; i < n; i++) chk(tag, 64'(got_q1.pop_front()), 64'(exp_q1.pop_front()));
            got_q1.delete();
            exp_q1.delete();
        end else begin
            chk({tag, "_count"}, 64'(got_q4.size()), 64'(exp_q4.size()));
            n = (got_q4.size() < exp_q4.size()) ? got_q4.size() : exp_q4.size();
            for (int i = 0; i < n; i++) chk(tag, 64'(got_q4.pop_front()), 64'(exp_q4.pop_front()));
            got_q4.delete();
            exp_q4.delete();
        end
    endtask

    task automatic snap4();
        b_blk = n_blk4; b_ok = n_ok4; b_done = n_done4; b_to = n_to4;
    endtask

    initial begin
        rstn = 1'b0; sdclk = 1'b0;
        sddat1 = 1'b1; sddat4 = 4'hF;
        start1 = 1'b0; stop1 = 1'b0; nblocks1 = '0;
        start4 = 1'b0; stop4 = 1'b0; nblocks4 = '0;
        wait_cycles(3);

        // Reset values
        chk("reset_u1", 64'({busy1, outen1, outbyte1, outaddr1, outblk1, blk_done1,
                             blk_crc_ok1, crc_err1, done1, timeout1}), 64'd0);
        chk("reset_u4", 64'({busy4, outen4, outbyte4, outaddr4, outblk4, blk_done4,
                             blk_crc_ok4, crc_err4, done4, timeout4}), 64'd0);
        rstn = 1'b1;
        wait_cycles(1);

        // 1-bit single block
        nblocks1 = 16'd1;
        pulse(1, 0);
        chk("t1_busy", 64'(busy1), 64'd1);
        idle_edges(3);
        send_block1(512);
        wait_cycles(4);
        chk("t1_blk_done", 64'(n_blk1), 64'd1);
        chk("t1_blk_ok", 64'(n_ok1), 64'd1);
        chk("t1_done", 64'(n_done1), 64'd1);
        chk("t1_crc_err", 64'(crc_err1), 64'd0);
        chk("t1_busy_end", 64'(busy1), 64'd0);
        chk("t1_addr_hold", 64'(outaddr1), 64'd511);
        drain(1, "t1_byte");

        // 4-bit three blocks, with a start pulse while busy that must be ignored
        snap4();
        nblocks4 = 16'd3;
        pulse(4, 0);
        chk("t2_busy", 64'(busy4), 64'd1);
        for (int b = 0; b < 3; b++) begin
            idle_edges(5);
            if (b == 1) begin
                nblocks4 = 16'd1;
                pulse(4, 0);
                chk("t2_ign_outblk", 64'(outblk4), 64'd1);
                chk("t2_ign_busy", 64'(busy4), 64'd1);
            end
            send_block4(b, 512, 0);
        end
        wait_cycles(4);
        chk("t2_blk_done", 64'(n_blk4 - b_blk), 64'd3);
        chk("t2_blk_ok", 64'(n_ok4 - b_ok), 64'd3);
        chk("t2_done", 64'(n_done4 - b_done), 64'd1);
        chk("t2_done_with_3rd", 64'(done_blk4), 64'(b_blk + 3));
        chk("t2_outblk", 64'(outblk4), 64'd2);
        chk("t2_busy_end", 64'(busy4), 64'd0);
        drain(4, "t2_byte");

        // CRC error on DAT2 in block 1 of 2
        snap4();
        nblocks4 = 16'd2;
        pulse(4, 0);
        idle_edges(5);
        send_block4(0, 512, 0);
        idle_edges(5);
        send_block4(1, 512, 1);
        wait_cycles(4);
        chk("t3_ok_hist", 64'(ok_hist4[1:0]), 64'd2);
        chk("t3_blk_done", 64'(n_blk4 - b_blk), 64'd2);
        chk("t3_crc_err", 64'(crc_err4), 64'd1);
        chk("t3_done", 64'(n_done4 - b_done), 64'd1);
        wait_cycles(20);
        chk("t3_crc_err_held", 64'(crc_err4), 64'd1);
        drain(4, "t3_byte");

        // Timeout after 100 edges; partial lows do not count as a start bit
        snap4();
        nblocks4 = 16'd1;
        pulse(4, 0);
        chk("t4_crc_err_clr", 64'(crc_err4), 64'd0);
        for (int e = 0; e < 99; e++) sd_edge(1'b1, (e >= 10 && e < 20) ? 4'b1110 : 4'hF);
        chk("t4_no_early_to", 64'(n_to4 - b_to), 64'd0);
        chk("t4_busy_wait", 64'(busy4), 64'd1);
        sd_edge(1'b1, 4'hF);
        chk("t4_timeout", 64'(timeout4), 64'd1);
        chk("t4_busy_low", 64'(busy4), 64'd0);
        wait_cycles(1);
        chk("t4_timeout_pulse", 64'(timeout4), 64'd0);
        chk("t4_to_count", 64'(n_to4 - b_to), 64'd1);
        chk("t4_no_outen", 64'(got_q4.size()), 64'd0);

        // Stop after byte 200, then a clean read
        snap4();
        nblocks4 = 16'd1;
        pulse(4, 0);
        idle_edges(2);
        send_block4(0, 201, 0);
        pulse(4, 1);
        chk("t5_busy_stop", 64'(busy4), 64'd0);
        for (int e = 0; e < 20; e++) sd_edge(1'b1, 4'h0);
        wait_cycles(4);
        chk("t5_no_done", 64'(n_done4 - b_done), 64'd0);
        chk("t5_no_blk_done", 64'(n_blk4 - b_blk), 64'd0);
        drain(4, "t5_byte");
        snap4();
        pulse(4, 0);
        idle_edges(2);
        send_block4(0, 512, 0);
        wait_cycles(4);
        chk("t5_restart_done", 64'(n_done4 - b_done), 64'd1);
        chk("t5_restart_ok", 64'(n_ok4 - b_ok), 64'd1);
        drain(4, "t5_restart_byte");

        // Asynchronous reset in the middle of a 1-bit payload
        b_blk = n_blk1; b_done = n_done1;
        pulse(1, 0);
        idle_edges(2);
        send_block1(3);
        for (int e = 0; e < 4; e++) sd_edge(1'b1, 4'hF);
        chk("t6_addr_before", 64'(outaddr1), 64'd2);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_async_clear", 64'({busy1, outen1, outbyte1, outaddr1, outblk1, blk_done1,
                                   blk_crc_ok1, crc_err1, done1, timeout1}), 64'd0);
        wait_cycles(2);
        rstn = 1'b1;
        wait_cycles(4);
        chk("t6_no_blk_done", 64'(n_blk1 - b_blk), 64'd0);
        chk("t6_no_done", 64'(n_done1 - b_done), 64'd0);
        chk("t6_idle", 64'(busy1), 64'd0);
        drain(1, "t6_byte");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_dat_reader.md
# sd_dat_reader

Parametrised SD-card DAT-line receiver for multi-block reads. It runs in the `clk` domain and samples the card clock generated by `sdcmd_ctrl`. It supports both 1-bit and 4-bit bus modes, receives one or more consecutive 512-byte blocks, and checks the per-line CRC16 and the end bit of each block. It sits beside `sdcmd_ctrl` in the next-generation SD host: the host FSM issues CMD17 or CMD18 and pulses `start`, then issues CMD12 once `done` fires.

## Interface
- `DAT_WIDTH`, default 1: bus width, legal values 1 or 4; any other value is a synthesis error.
- `TIMEOUT`, default 1000000: number of `sdclk` rising edges to wait for a start bit, per block.
- `clk` in 1: system clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `sdclk` in 1: card clock, a level from `sdcmd_ctrl`, not used as a clock.
- `sddat` in DAT_WIDTH: card DAT lines; bit 0 is DAT0.
- `start` in 1: one-cycle pulse that begins a read; ignored while `busy`.
- `nblocks` in 16: number of blocks to receive, latched on `start`; 0 is treated as 1.
- `stop` in 1: abort; has priority over everything except reset.
- `busy` out 1: high from the cycle after an accepted `start` until return to IDLE.
- `outen` out 1: one-cycle byte strobe.
- `outbyte` out 8: received byte, valid with `outen`.
- `outaddr` out 9: byte index within the block, 0..511.
- `outblk` out 16: block index, 0..nblocks-1.
- `blk_done` out 1: one-cycle pulse at the end of each block.
- `blk_crc_ok` out 1: valid with `blk_done`; 1 when all line CRCs match and the end bit is 1 on every line.
- `crc_err` out 1: sticky, set by any failing block, cleared by an accepted `start`.
- `done` out 1: one-cycle pulse after the last block.
- `timeout` out 1: one-cycle pulse when the start-bit wait expires.

## Operation
- Edge detect: `sdclk_l` <= `sdclk` every cycle. A sample cycle is any cycle with `~sdclk_l & sdclk`. All FSM actions below happen only on sample cycles, except `start`, `stop` and reset.
- States are IDLE, WAIT, DATA, CRC and ENDB.
- IDLE: when `start` is high, latch `nblocks` (0 becomes 1), clear `outblk`, `crc_err` and the edge counter, then go to WAIT.
- WAIT:
  - Start bit is `sddat[0]==0` when DAT_WIDTH=1, and `sddat==4'b0000` when DAT_WIDTH=4. A partial low in 4-bit mode is not a start bit.
  - On a start bit: go to DATA, clear the bit counter and all CRC registers.
  - Otherwise increment the edge counter. When the counter reaches TIMEOUT, pulse `timeout` and go to IDLE.
- DATA, 1-bit mode: 8 samples per byte, MSB first.
- DATA, 4-bit mode: 2 samples per byte, high nibble first; DAT3 carries the nibble MSB.
- After 4096/DAT_WIDTH samples, go to CRC.
- CRC: 16 samples. Each line shifts its received CRC bits, MSB first. Each line's CRC16 is computed over only that line's data bits: polynomial x^16+x^12+x^5+1, init 0.
- ENDB: one sample, which must be 1 on every line.
  - Pulse `blk_done` and set `blk_crc_ok`. On a failure, set `crc_err`.
  - If the block just finished was the last one, pulse `done` in the same cycle and go to IDLE.
  - Otherwise increment `outblk`, clear the edge counter and go to WAIT.
- `stop`: in the next cycle go to IDLE, with `busy` low and no `done`, `blk_done` or `timeout` pulse. Already-emitted bytes remain valid.
- `start` and `stop` high in the same cycle while IDLE: stop wins and the FSM stays in IDLE.

## Timing
- Reset values: all outputs 0, `sdclk_l` 0, FSM in IDLE, all counters and CRC registers 0.
- Output update and hold:
  - All outputs are registered. Values from sample cycle S are visible in cycle S+1.
  - Pulses last exactly one cycle.
  - `outbyte`, `outaddr` and `outblk` hold their values between strobes.
- An `sdclk` edge in the same cycle as an accepted `start` is not sampled. The first eligible edge is in the following cycle.
- `outen` fires on the sample that completes a byte: the 8th sample in 1-bit mode, the 2nd in 4-bit mode.
- `blk_done`, `blk_crc_ok` and (on the last block) `done` are asserted together in the cycle after the end-bit sample. `busy` drops in that same cycle on the last block.
- Edge counter width: 32 bits. The timeout comparison is `>= TIMEOUT`.
- Asynchronous reset mid-block: immediate return to reset values; no pulses are generated.

## Test plan
- **1-bit single block:** DAT_WIDTH=1, nblocks=1, payload bytes i&0xFF, correct CRC, end bit 1.
  - Response: 512 `outen` strobes; `outaddr` 0..511 with matching bytes; `blk_crc_ok`=1; `done` once; `crc_err`=0.
- **4-bit multi-block:** DAT_WIDTH=4, nblocks=3, block b carrying byte (i+b)&0xFF, 5 idle edges between blocks.
  - Response: 1536 strobes; `outblk` 0,1,2; 3 `blk_done` pulses, all ok; `done` coincides with the 3rd `blk_done`.
- **CRC error:** 4-bit mode, CRC bit 5 of DAT2 flipped in block 1 of 2.
  - Response: block 0 ok, block 1 `blk_crc_ok`=0; `crc_err`=1 and held until the next `start`; `done` still pulses.
- **Timeout:** TIMEOUT=100, DAT held high.
  - Response: `timeout` pulses after the 100th sample edge, `busy` goes low, no `outen`.
  - Partial start `sddat`=4'b1110 in 4-bit mode is ignored and does not reset the counter.
- **Stop mid-block:** `stop` asserted after byte 200 of block 0.
  - Response: `busy` goes low in the next cycle, no further `outen`, no `done`.
  - A new `start` afterwards reads correctly.
- **Reset and ignored start:** `rstn` pulled low mid-DATA clears all outputs asynchronously. A `start` pulse while `busy` neither changes `outblk` nor re-latches `nblocks`.
